// File: rtl/wiegand_pkg.sv
// Shared Wiegand-26 definitions: frame layout, controller state encoding and
// the parity/field decode used when a buffered frame is presented to the host.
package wiegand_pkg;

    localparam int WG_BITS   = 26;
    localparam int FAC_MSB   = 24;
    localparam int FAC_LSB   = 17;
    localparam int CARD_MSB  = 16;
    localparam int CARD_LSB  = 1;
    localparam int PAR_SPLIT = 13;
    localparam int FAC_W     = FAC_MSB - FAC_LSB + 1;
    localparam int CARD_W    = CARD_MSB - CARD_LSB + 1;

    typedef logic [WG_BITS-1:0] wg_frame_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_GAP     = 2'd2
    } wg_state_e;

    typedef struct packed {
        logic [FAC_W-1:0]  facility;
        logic [CARD_W-1:0] card;
        logic              perr;
    } wg_fields_t;

    // Leading half carries even parity, trailing half odd parity.
    function automatic logic wg_parity_err(input wg_frame_t d);
        return (^d[WG_BITS-1:PAR_SPLIT]) | ~(^d[PAR_SPLIT-1:0]);
    endfunction

    function automatic wg_fields_t wg_decode(input wg_frame_t d);
        wg_fields_t f;
        f.facility = d[FAC_MSB:FAC_LSB];
        f.card     = d[CARD_MSB:CARD_LSB];
        f.perr     = wg_parity_err(d);
        return f;
    endfunction

endpackage

// File: rtl/wg_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting port found
// scanning ptr+1, ptr+2, ... modulo N_PORTS.
module wg_rr_arbiter #(
    parameter int N_PORTS = 2,
    parameter int PW      = 1
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [N_PORTS-1:0] gnt_oh,
    output logic [PW-1:0]      gnt_idx,
    output logic               gnt_valid
);

    logic [PW-1:0] cand;

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        gnt_oh    = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            cand = PW'((int'(ptr) + k) % N_PORTS);
            if (!gnt_valid && req[cand]) begin
                gnt_valid    = 1'b1;
                gnt_idx      = cand;
                gnt_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wiegand_frame_ctrl.sv
// Buffers one Wiegand-26 frame per receiver port and presents them to the host
// one at a time, round-robin, with an int/ack handshake and an ack timeout.
module wiegand_frame_ctrl
    import wiegand_pkg::*;
#(
    parameter int N_PORTS     = 2,
    parameter int PW          = 1,
    parameter int ACK_TIMEOUT = 5000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PORTS-1:0]         frm_valid,
    input  logic [WG_BITS*N_PORTS-1:0] frm_data,
    input  logic                       host_ack,
    output logic                       int_o,
    output logic [PW-1:0]              out_port,
    output logic [FAC_W-1:0]           out_facility,
    output logic [CARD_W-1:0]          out_card,
    output logic                       out_perr,
    output logic                       out_ovr,
    output logic                       tmo
);

    localparam int             TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0]  TMO_SAT  = TW'(ACK_TIMEOUT);
    localparam logic [PW-1:0]  PTR_RST  = PW'(N_PORTS - 1);

    wg_frame_t [N_PORTS-1:0] slot_q, slot_d;
    logic [N_PORTS-1:0]      full_q, full_d;
    logic [N_PORTS-1:0]      ovr_q, ovr_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    wg_state_e               state_q, state_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic                    int_q, int_d;
    logic                    tmo_q, tmo_d;
    logic [PW-1:0]           port_q, port_d;
    logic [FAC_W-1:0]        fac_q, fac_d;
    logic [CARD_W-1:0]       card_q, card_d;
    logic                    perr_q, perr_d;
    logic                    oovr_q, oovr_d;

    logic [N_PORTS-1:0]      gnt_oh;
    logic [PW-1:0]           gnt_idx;
    logic                    gnt_valid;
    logic [N_PORTS-1:0]      take_oh;
    wg_fields_t              fields;

    wg_rr_arbiter #(
        .N_PORTS (N_PORTS),
        .PW      (PW)
    ) u_arb (
        .req       (full_q),
        .ptr       (ptr_q),
        .gnt_oh    (gnt_oh),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        slot_d  = slot_q;
        full_d  = full_q;
        ovr_d   = ovr_q;
        ptr_d   = ptr_q;
        state_d = state_q;
        tcnt_d  = tcnt_q;
        int_d   = int_q;
        tmo_d   = 1'b0;
        port_d  = port_q;
        fac_d   = fac_q;
        card_d  = card_q;
        perr_d  = perr_q;
        oovr_d  = oovr_q;
        fields  = wg_decode(slot_q[gnt_idx]);
        take_oh = (state_q == ST_IDLE && gnt_valid) ? gnt_oh : '0;

        // A slot being drained this cycle can accept a new frame without overrun.
        for (int i = 0; i < N_PORTS; i++) begin
            if (take_oh[i]) begin
                full_d[i] = 1'b0;
                ovr_d[i]  = 1'b0;
            end
            if (frm_valid[i]) begin
                if (!full_q[i] || take_oh[i]) begin
                    slot_d[i] = frm_data[i*WG_BITS +: WG_BITS];
                    full_d[i] = 1'b1;
                end else begin
                    ovr_d[i] = 1'b1;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    port_d  = gnt_idx;
                    fac_d   = fields.facility;
                    card_d  = fields.card;
                    perr_d  = fields.perr;
                    oovr_d  = ovr_q[gnt_idx];
                    ptr_d   = gnt_idx;
                    tcnt_d  = '0;
                    int_d   = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (host_ack) begin
                    int_d   = 1'b0;
                    state_d = ST_GAP;
                end else if (tcnt_q == TMO_LAST) begin
                    int_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = ST_GAP;
                end else if (tcnt_q != TMO_SAT) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                int_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= '0;
            ovr_q   <= '0;
            ptr_q   <= PTR_RST;
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            int_q   <= 1'b0;
            tmo_q   <= 1'b0;
            port_q  <= '0;
            fac_q   <= '0;
            card_q  <= '0;
            perr_q  <= 1'b0;
            oovr_q  <= 1'b0;
        end else begin
            full_q  <= full_d;
            ovr_q   <= ovr_d;
            ptr_q   <= ptr_d;
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            int_q   <= int_d;
            tmo_q   <= tmo_d;
            port_q  <= port_d;
            fac_q   <= fac_d;
            card_q  <= card_d;
            perr_q  <= perr_d;
            oovr_q  <= oovr_d;
        end
    end

    // NOTE: slot data needs no reset; full_q alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign int_o        = int_q;
    assign tmo          = tmo_q;
    assign out_port     = port_q;
    assign out_facility = fac_q;
    assign out_card     = card_q;
    assign out_perr     = perr_q;
    assign out_ovr      = oovr_q;

endmodule

// File: tb/tb_wiegand_frame_ctrl.sv
// Directed bench for wiegand_frame_ctrl: a table of single-frame vectors plus
// hand-written sequences for arbitration, overrun, timeout and reset.
module tb_wiegand_frame_ctrl;

    localparam int N_PORTS = 2;
    localparam int PW      = 1;
    localparam int T       = 20;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_PORTS-1:0]   frm_valid;
    logic [26*N_PORTS-1:0] frm_data;
    logic                 host_ack;
    logic                 int_o;
    logic [PW-1:0]        out_port;
    logic [7:0]           out_facility;
    logic [15:0]          out_card;
    logic                 out_perr;
    logic                 out_ovr;
    logic                 tmo;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        int          port;
        logic [25:0] data;
        logic [7:0]  fac;
        logic [15:0] card;
        logic        perr;
    } vec_t;

    vec_t vecs[7];

    wiegand_frame_ctrl #(
        .N_PORTS     (N_PORTS),
        .PW          (PW),
        .ACK_TIMEOUT (T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frm_valid    (frm_valid),
        .frm_data     (frm_data),
        .host_ack     (host_ack),
        .int_o        (int_o),
        .out_port     (out_port),
        .out_facility (out_facility),
        .out_card     (out_card),
        .out_perr     (out_perr),
        .out_ovr      (out_ovr),
        .tmo          (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge; single-cycle pulses are dropped right after it.
    task automatic tick();
        @(posedge clk);
        #1;
        frm_valid = '0;
        host_ack  = 1'b0;
    endtask

    task automatic drive_frame(input int p, input logic [25:0] d);
        frm_valid[p]        = 1'b1;
        frm_data[p*26 +: 26] = d;
    endtask

    task automatic check_frame(input string tag, input logic [PW-1:0] p, input logic [15:0] card,
                               input logic ovr);
        check({tag, "_int"}, 32'(int_o), 32'd1);
        check({tag, "_port"}, 32'(out_port), 32'(p));
        check({tag, "_card"}, 32'(out_card), 32'(card));
        check({tag, "_ovr"}, 32'(out_ovr), 32'(ovr));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        vecs[0] = '{0, 26'h2468AC,  8'h12, 16'h3456, 1'b0};
        vecs[1] = '{0, 26'h2468AD,  8'h12, 16'h3456, 1'b1};
        vecs[2] = '{1, 26'h0000000, 8'h00, 16'h0000, 1'b1};
        vecs[3] = '{1, 26'h3FFFFFF, 8'hFF, 16'hFFFF, 1'b1};
        vecs[4] = '{0, 26'h0000001, 8'h00, 16'h0000, 1'b0};
        vecs[5] = '{1, 26'h2000000, 8'h00, 16'h0000, 1'b1};
        vecs[6] = '{0, 26'h1FFFFFF, 8'hFF, 16'hFFFF, 1'b0};

        rst       = 1'b1;
        frm_valid = '0;
        frm_data  = '0;
        host_ack  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_int", 32'(int_o), 32'd0);
        check("rst_tmo", 32'(tmo), 32'd0);
        check("rst_fields", {out_facility, out_card, 5'(out_port), out_perr, out_ovr}, 32'd0);

        // Single-frame vectors: latency, field split, parity, ack release.
        for (int v = 0; v < 7; v++) begin
            drive_frame(vecs[v].port, vecs[v].data);
            tick();
            check($sformatf("v%0d_int_e0", v), 32'(int_o), 32'd0);
            tick();
            check_frame($sformatf("v%0d", v), PW'(vecs[v].port), vecs[v].card, 1'b0);
            check($sformatf("v%0d_fac", v), 32'(out_facility), 32'(vecs[v].fac));
            check($sformatf("v%0d_perr", v), 32'(out_perr), 32'(vecs[v].perr));
            host_ack = 1'b1;
            tick();
            check($sformatf("v%0d_int_ack", v), 32'(int_o), 32'd0);
            check($sformatf("v%0d_tmo", v), 32'(tmo), 32'd0);
            tick();
        end

        // Simultaneous arrival from reset, then round-robin order.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_frame(0, 26'h2468AC);
        drive_frame(1, 26'h1FFFFFF);
        tick();
        tick();
        check_frame("rr_first", 1'b0, 16'h3456, 1'b0);
        host_ack = 1'b1;
        tick();
        check("rr_gap_int", 32'(int_o), 32'd0);
        tick();
        check("rr_idle_int", 32'(int_o), 32'd0);
        tick();
        check_frame("rr_second", 1'b1, 16'hFFFF, 1'b0);
        drive_frame(0, 26'h0000001);
        drive_frame(1, 26'h2468AD);
        tick();
        host_ack = 1'b1;
        tick();
        tick();
        tick();
        check_frame("rr_wrap_p0", 1'b0, 16'h0000, 1'b0);
        host_ack = 1'b1;
        tick();
        tick();
        tick();
        check_frame("rr_then_p1", 1'b1, 16'h3456, 1'b0);
        host_ack = 1'b1;
        tick();
        tick();

        // Overrun on port 1 while port 0 is held, plus capture on the grant cycle.
        drive_frame(0, 26'h2468AC);
        tick();
        tick();
        drive_frame(1, 26'h1FFFFFF);
        tick();
        drive_frame(1, 26'h0000001);
        tick();
        drive_frame(1, 26'h2000000);
        tick();
        check_frame("ovr_hold", 1'b0, 16'h3456, 1'b0);
        host_ack = 1'b1;
        tick();
        tick();
        drive_frame(1, 26'h2468AC);
        tick();
        check_frame("ovr_first", 1'b1, 16'hFFFF, 1'b1);
        host_ack = 1'b1;
        tick();
        tick();
        tick();
        check_frame("ovr_next", 1'b1, 16'h3456, 1'b0);
        check("ovr_next_perr", 32'(out_perr), 32'd0);
        host_ack = 1'b1;
        tick();
        tick();

        // Ack timeout with another port pending.
        drive_frame(0, 26'h2468AC);
        drive_frame(1, 26'h1FFFFFF);
        tick();
        tick();
        check_frame("tmo_p0", 1'b0, 16'h3456, 1'b0);
        bad = 0;
        for (int i = 1; i < T; i++) begin
            tick();
            if (int_o !== 1'b1 || tmo !== 1'b0) bad++;
        end
        check("tmo_wait_clean", 32'(bad), 32'd0);
        tick();
        check("tmo_pulse", 32'(tmo), 32'd1);
        check("tmo_int_low", 32'(int_o), 32'd0);
        tick();
        check("tmo_pulse_end", 32'(tmo), 32'd0);
        check("tmo_idle_int", 32'(int_o), 32'd0);
        tick();
        check_frame("tmo_next_p1", 1'b1, 16'hFFFF, 1'b0);
        for (int i = 1; i < T; i++) tick();
        host_ack = 1'b1;
        tick();
        check("ack_vs_tmo_tmo", 32'(tmo), 32'd0);
        check("ack_vs_tmo_int", 32'(int_o), 32'd0);
        tick();
        check("ack_vs_tmo_after", 32'(tmo), 32'd0);

        // Reset while presenting with both slots full.
        drive_frame(0, 26'h2468AC);
        tick();
        tick();
        drive_frame(0, 26'h1FFFFFF);
        drive_frame(1, 26'h0000001);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst6_int", 32'(int_o), 32'd0);
        check("rst6_fields", {out_facility, out_card, 5'(out_port), out_perr, out_ovr}, 32'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (int_o !== 1'b0) bad++;
        end
        check("rst6_no_frame", 32'(bad), 32'd0);
        drive_frame(1, 26'h2468AC);
        tick();
        tick();
        check_frame("rst6_new", 1'b1, 16'h3456, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
